vga_sync_capture: RTL and testbench

TinyQV peripheral that receives a 6-bit-colour VGA signal on the input PMOD. It measures horizontal and vertical sync timing and captures 16 colour samples from one software-selected scanline into a readable buffer. It is the receiving end of the team's VGA output peripheral and is used for loopback self-test and for monitoring an external video source from firmware.

---
 rtl/vga_sync_capture.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_vga_sync_capture.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_capture.sv
// vga_sync_capture: receives a 6-bit-colour VGA signal on ui_in, measures
// hsync/vsync timing and captures 16 colour samples from one selected line.
// Optional macro VGA_CAPTURE_MEASURE_EN builds the H_PERIOD, H_PULSE and
// V_LINES measurement registers; when it is undefined those registers read 0.
//
// Bus handshake: the register port never stalls (data_ready is tied 1). A
// write is any data_write_n other than 2'b11 and lands on the next clock
// edge; data_out is a purely combinational decode of address.
module vga_sync_capture #(
  parameter int NUM_SAMPLES = 16,
  parameter int CNT_W       = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  localparam int IDX_W = $clog2(NUM_SAMPLES);
  localparam int NUM_WORDS = NUM_SAMPLES / 4;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARMED     = 3'd1,
    S_WAIT_LINE = 3'd2,
    S_WAIT_X    = 3'd3,
    S_SAMPLE    = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  // Input decode: syncs are active-low, colour is reassembled as {B,G,R} pairs.
  logic       w_hsync;
  logic       w_vsync;
  logic [5:0] w_colour;
  assign w_hsync  = ui_in[7];
  assign w_vsync  = ui_in[3];
  assign w_colour = {ui_in[6], ui_in[2], ui_in[5], ui_in[1], ui_in[4], ui_in[0]};

  // Bus decode.
  logic w_wr;
  logic w_arm;
  logic w_abort;
  assign w_wr    = (data_write_n != 2'b11);
  assign w_abort = w_wr && (address == 6'h00) && data_in[1];
  assign w_arm   = w_wr && (address == 6'h00) && data_in[0];

  // Read strobe and upper write bits carry no information for this block.
  logic w_unused;
  assign w_unused = ^{data_read_n, data_in[31:CNT_W]};

  logic [9:0]       r_line_sel;
  logic [CNT_W-1:0] r_x_start;
  logic [6:0]       r_sample_div;
  logic             r_hs_d;
  logic             r_vs_d;
  logic [9:0]       r_line_cnt;
  logic             r_frame_seen;
  state_t           r_state;
  logic [CNT_W-1:0] r_x_cnt;
  logic [6:0]       r_d_cnt;
  logic [IDX_W-1:0] r_s_idx;
  logic             r_truncated;
  logic [5:0]       r_buf [NUM_SAMPLES];

  logic w_hs_fall;
  logic w_vs_fall;
  assign w_hs_fall = r_hs_d & ~w_hsync;
  assign w_vs_fall = r_vs_d & ~w_vsync;

  // Software-writable configuration registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_line_sel   <= '0;
      r_x_start    <= '0;
      r_sample_div <= '0;
    end else if (w_wr) begin
      case (address)
        6'h04: r_line_sel   <= data_in[9:0];
        6'h08: r_x_start    <= data_in[CNT_W-1:0];
        6'h0C: r_sample_div <= data_in[6:0];
        default: ;
      endcase
    end
  end

  // Previous-cycle sync levels for edge detection; idle level is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hs_d <= 1'b1;
      r_vs_d <= 1'b1;
    end else begin
      r_hs_d <= w_hsync;
      r_vs_d <= w_vsync;
    end
  end

  // Line tracking: a vsync fall restarts the count; a coincident hsync fall
  // is line 0 of the new frame, so the count lands on 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_line_cnt   <= '0;
      r_frame_seen <= 1'b0;
    end else if (w_vs_fall) begin
      r_line_cnt   <= w_hs_fall ? 10'd1 : 10'd0;
      r_frame_seen <= 1'b1;
    end else if (w_hs_fall && (r_line_cnt != 10'h3FF)) begin
      r_line_cnt <= r_line_cnt + 10'd1;
    end
  end

  logic [9:0] w_line_idx;
  assign w_line_idx = w_vs_fall ? 10'd0 : r_line_cnt;

  logic [CNT_W-1:0] w_h_period;
  logic [CNT_W-1:0] w_h_pulse;
  logic [9:0]       w_v_lines;

`ifdef VGA_CAPTURE_MEASURE_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             w_hs_rise;
  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_p_cnt;
  logic [CNT_W-1:0] r_h_period;
  logic [CNT_W-1:0] r_h_pulse;
  logic [9:0]       r_v_lines;
  assign w_hs_rise = ~r_hs_d & w_hsync;

  // Line period: cycles between successive hsync falls, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h_cnt    <= '0;
      r_h_period <= '0;
    end else if (w_hs_fall) begin
      r_h_cnt    <= CNT_W'(1);
      r_h_period <= r_h_cnt;
    end else if (r_h_cnt != CNT_MAX) begin
      r_h_cnt <= r_h_cnt + CNT_W'(1);
    end
  end

  // Sync pulse width: cycles with hsync low, latched on the rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_p_cnt   <= '0;
      r_h_pulse <= '0;
    end else if (w_hs_rise) begin
      r_h_pulse <= r_p_cnt;
      r_p_cnt   <= '0;
    end else if (!w_hsync && (r_p_cnt != CNT_MAX)) begin
      r_p_cnt <= r_p_cnt + CNT_W'(1);
    end
  end

  // Frame height: line count captured at each vsync fall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v_lines <= '0;
    end else if (w_vs_fall) begin
      r_v_lines <= r_line_cnt;
    end
  end

  assign w_h_period = r_h_period;
  assign w_h_pulse  = r_h_pulse;
  assign w_v_lines  = r_v_lines;
`else
  assign w_h_period = '0;
  assign w_h_pulse  = '0;
  assign w_v_lines  = '0;
`endif

  // Capture start at edge E. A vsync restart that coincides with the hsync
  // fall of line 0 can start immediately, otherwise LINE_SEL = 0 would never
  // be reachable on sources whose syncs fall together.
  logic w_in_capture;
  logic w_start;
  assign w_in_capture = (r_state == S_ARMED) || (r_state == S_WAIT_LINE) ||
                        (r_state == S_WAIT_X) || (r_state == S_SAMPLE);
  assign w_start = w_hs_fall && (w_line_idx == r_line_sel) &&
                   ((r_state == S_WAIT_LINE) || (w_vs_fall && w_in_capture));

  // Capture FSM: abort beats arm, arm beats everything else, vsync restarts
  // beat line truncation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_x_cnt     <= '0;
      r_d_cnt     <= '0;
      r_s_idx     <= '0;
      r_truncated <= 1'b0;
      for (int i = 0; i < NUM_SAMPLES; i++) r_buf[i] <= '0;
    end else if (w_abort) begin
      r_state     <= S_IDLE;
    end else if (w_arm) begin
      r_state     <= S_ARMED;
      r_truncated <= 1'b0;
      for (int i = 0; i < NUM_SAMPLES; i++) r_buf[i] <= '0;
    end else if (w_start) begin
      for (int i = 0; i < NUM_SAMPLES; i++) r_buf[i] <= '0;
      if (r_x_start == '0) begin
        r_buf[0] <= w_colour;
        r_s_idx  <= IDX_W'(1);
        r_d_cnt  <= r_sample_div;
        r_state  <= S_SAMPLE;
      end else begin
        r_x_cnt  <= r_x_start;
        r_state  <= S_WAIT_X;
      end
    end else if (w_vs_fall && w_in_capture) begin
      r_state <= S_WAIT_LINE;
      for (int i = 0; i < NUM_SAMPLES; i++) r_buf[i] <= '0;
    end else begin
      case (r_state)
        S_WAIT_X: begin
          if (w_hs_fall) begin
            r_state     <= S_DONE;
            r_truncated <= 1'b1;
          end else if (r_x_cnt == CNT_W'(1)) begin
            r_buf[0] <= w_colour;
            r_s_idx  <= IDX_W'(1);
            r_d_cnt  <= r_sample_div;
            r_state  <= S_SAMPLE;
          end else begin
            r_x_cnt <= r_x_cnt - CNT_W'(1);
          end
        end
        S_SAMPLE: begin
          if (w_hs_fall) begin
            r_state     <= S_DONE;
            r_truncated <= 1'b1;
          end else if (r_d_cnt == '0) begin
            r_buf[r_s_idx] <= w_colour;
            if (r_s_idx == IDX_W'(NUM_SAMPLES - 1)) begin
              r_state <= S_DONE;
            end else begin
              r_s_idx <= r_s_idx + IDX_W'(1);
              r_d_cnt <= r_sample_div;
            end
          end else begin
            r_d_cnt <= r_d_cnt - 7'd1;
          end
        end
        default: ;
      endcase
    end
  end

  logic w_busy;
  logic w_done;
  assign w_busy = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_done = (r_state == S_DONE);

  // Buffer packing: four 6-bit samples per word, two zero bits above each.
  logic [31:0] w_buf_word [NUM_WORDS];
  always_comb begin
    for (int n = 0; n < NUM_WORDS; n++) begin
      w_buf_word[n] = {2'b00, r_buf[4*n+3], 2'b00, r_buf[4*n+2],
                       2'b00, r_buf[4*n+1], 2'b00, r_buf[4*n]};
    end
  end

  // Register read mux; unmapped addresses read 0.
  always_comb begin
    data_out = '0;
    case (address)
      6'h00: data_out = {28'd0, r_truncated, w_done, w_busy, r_frame_seen};
      6'h04: data_out = {22'd0, r_line_sel};
      6'h08: data_out = {{(32-CNT_W){1'b0}}, r_x_start};
      6'h0C: data_out = {25'd0, r_sample_div};
      6'h10: data_out = {{(32-CNT_W){1'b0}}, w_h_period};
      6'h14: data_out = {{(32-CNT_W){1'b0}}, w_h_pulse};
      6'h18: data_out = {22'd0, w_v_lines};
      6'h20: data_out = w_buf_word[0];
      6'h24: data_out = w_buf_word[1];
      6'h28: data_out = w_buf_word[2];
      6'h2C: data_out = w_buf_word[3];
      default: data_out = '0;
    endcase
  end

  assign uo_out         = 8'h00;
  assign data_ready     = 1'b1;
  assign user_interrupt = w_done;

endmodule

// File: tb/tb_vga_sync_capture.sv
// Directed bench for vga_sync_capture: register table, synthetic video
// frames from a line/frame generator, and hand-stepped sync sequences.
module tb_vga_sync_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ui_in;
  logic [7:0]  uo_out;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  int n_run  = 0;
  int n_fail = 0;

`ifdef VGA_CAPTURE_MEASURE_EN
  localparam bit MEAS = 1'b1;
`else
  localparam bit MEAS = 1'b0;
`endif

  localparam logic [5:0] A_CTRL = 6'h00, A_LSEL = 6'h04, A_XST = 6'h08,
                         A_DIV = 6'h0C, A_HPER = 6'h10, A_HPUL = 6'h14,
                         A_VLIN = 6'h18, A_BUF0 = 6'h20;

  vga_sync_capture dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ui_in          (ui_in),
    .uo_out         (uo_out),
    .address        (address),
    .data_in        (data_in),
    .data_write_n   (data_write_n),
    .data_read_n    (data_read_n),
    .data_out       (data_out),
    .data_ready     (data_ready),
    .user_interrupt (user_interrupt)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] pack(logic hs, logic vs, logic [5:0] c);
    return {hs, c[5], c[3], c[1], vs, c[4], c[2], c[0]};
  endfunction

  // Video generator: colour is the cycle count since the hsync fall, mod 64.
  int          g_h = 1344, g_pw = 136, g_v = 4, g_vsw = 1;
  bit          g_en = 1'b0;
  int          hpos = 0, vline = 0;
  logic [7:0]  r_gen = 8'h88;
  logic [7:0]  r_man = 8'h88;
  assign ui_in = g_en ? r_gen : r_man;

  always @(negedge clk) begin
    if (!g_en) begin
      hpos  = 0;
      vline = 0;
      r_gen = 8'h88;
    end else begin
      r_gen = pack(hpos >= g_pw, vline >= g_vsw, 6'(hpos % 64));
      hpos++;
      if (hpos == g_h) begin
        hpos = 0;
        vline++;
        if (vline == g_v) vline = 0;
      end
    end
  end

  // Scoreboard helpers.
  function automatic void check(string nm, logic [31:0] got, logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    end
  endfunction

  // Expected buffer word for a generator capture: sample k sits at line
  // offset X + k*(D+1); offsets past the line end were never taken.
  function automatic logic [31:0] gen_word(int n, int x, int d, int h);
    logic [31:0] w = '0;
    for (int j = 0; j < 4; j++) begin
      int off = x + (4*n + j) * (d + 1);
      if (off < h) w[8*j +: 8] = {2'b00, 6'(off % 64)};
    end
    return w;
  endfunction

  function automatic logic [5:0] man_colour(int k);
    return 6'((7*k + 5) % 64);
  endfunction

  // Driver tasks.
  task automatic bus_wr(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    address      = a;
    data_in      = d;
    data_write_n = 2'b00;
    @(negedge clk);
    data_write_n = 2'b11;
  endtask

  task automatic bus_rd(input logic [5:0] a, output logic [31:0] d);
    address     = a;
    data_read_n = 2'b00;
    #1;
    d           = data_out;
    data_read_n = 2'b11;
  endtask

  task automatic check_reg(input string nm, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] got;
    bus_rd(a, got);
    check(nm, got, exp);
  endtask

  task automatic step(input logic hs, input logic vs, input logic [5:0] c);
    @(negedge clk);
    r_man = pack(hs, vs, c);
    @(posedge clk);
    #1;
  endtask

  task automatic gen_start(input int h, input int pw, input int v);
    g_h = h; g_pw = pw; g_v = v; g_vsw = 1;
    @(posedge clk);
    #2;
    g_en = 1'b1;
  endtask

  task automatic gen_stop();
    @(posedge clk);
    #2;
    g_en = 1'b0;
  endtask

  task automatic wait_irq(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (user_interrupt) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t tbl[7];
  bit       ok;
  bit       irq_seen;

  initial begin
    tbl[0] = '{A_LSEL, 32'hFFFF_FFFF, 32'h0000_03FF};
    tbl[1] = '{A_XST,  32'hFFFF_FFFF, 32'h0000_0FFF};
    tbl[2] = '{A_DIV,  32'hFFFF_FFFF, 32'h0000_007F};
    tbl[3] = '{A_LSEL, 32'h0000_0155, 32'h0000_0155};
    tbl[4] = '{A_XST,  32'h0000_A5A5, 32'h0000_05A5};
    tbl[5] = '{A_DIV,  32'h0000_0081, 32'h0000_0001};
    tbl[6] = '{A_HPER, 32'h0000_0FFF, 32'h0000_0000};

    rst_n        = 1'b0;
    address      = '0;
    data_in      = '0;
    data_write_n = 2'b11;
    data_read_n  = 2'b11;
    repeat (4) @(negedge clk);

    // Reset state.
    check_reg("rst_status", A_CTRL, 32'h0);
    check_reg("rst_hper",   A_HPER, 32'h0);
    check_reg("rst_hpul",   A_HPUL, 32'h0);
    check_reg("rst_vlin",   A_VLIN, 32'h0);
    check_reg("rst_buf0",   A_BUF0, 32'h0);
    check_reg("rst_buf3",   6'h2C,  32'h0);
    check_reg("rst_lsel",   A_LSEL, 32'h0);
    check("rst_irq",   {31'd0, user_interrupt}, 32'h0);
    check("rst_uo",    {24'd0, uo_out}, 32'h0);
    check("rst_ready", {31'd0, data_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Register write/readback table.
    for (int i = 0; i < 7; i++) begin
      bus_wr(tbl[i].addr, tbl[i].wdata);
      check_reg($sformatf("reg_rw%0d", i), tbl[i].addr, tbl[i].exp);
    end
    check_reg("unmapped_1c", 6'h1C, 32'h0);

    // Timing measurement: 1344-cycle lines, 136-cycle pulse, 4-line frames.
    gen_start(1344, 136, 4);
    repeat (2*4*1344 + 200) @(negedge clk);
    gen_stop();
    check_reg("meas_hper", A_HPER, MEAS ? 32'd1344 : 32'd0);
    check_reg("meas_hpul", A_HPUL, MEAS ? 32'd136  : 32'd0);
    check_reg("meas_vlin", A_VLIN, MEAS ? 32'd4    : 32'd0);
    check_reg("meas_status", A_CTRL, 32'h1);

    // Capture line 5, X_START 10, SAMPLE_DIV 3.
    bus_wr(A_LSEL, 32'd5);
    bus_wr(A_XST,  32'd10);
    bus_wr(A_DIV,  32'd3);
    bus_wr(A_CTRL, 32'h1);
    check_reg("cap_armed_status", A_CTRL, 32'h3);
    check("cap_armed_irq", {31'd0, user_interrupt}, 32'h0);
    gen_start(100, 10, 8);
    wait_irq(2000, ok);
    gen_stop();
    check("cap_irq_timeout", {31'd0, ok}, 32'h1);
    check_reg("cap_status", A_CTRL, 32'h5);
    check_reg("cap_buf0_hand", A_BUF0, 32'h1612_0E0A);
    for (int n = 1; n < 4; n++)
      check_reg($sformatf("cap_buf%0d", n), 6'(32'h20 + 4*n), gen_word(n, 10, 3, 100));

    // Truncation: samples run past the end of a 1344-cycle line.
    bus_wr(A_LSEL, 32'd2);
    bus_wr(A_XST,  32'd1300);
    bus_wr(A_DIV,  32'd7);
    bus_wr(A_CTRL, 32'h1);
    gen_start(1344, 136, 8);
    wait_irq(12000, ok);
    gen_stop();
    check("trunc_irq_timeout", {31'd0, ok}, 32'h1);
    check_reg("trunc_status", A_CTRL, 32'hD);
    check_reg("trunc_buf0_hand", A_BUF0, 32'h2C24_1C14);
    for (int n = 1; n < 4; n++)
      check_reg($sformatf("trunc_buf%0d", n), 6'(32'h20 + 4*n), gen_word(n, 1300, 7, 1344));

    // LINE_SEL beyond the frame height: stays busy, never interrupts.
    bus_wr(A_LSEL, 32'd900);
    bus_wr(A_XST,  32'd0);
    bus_wr(A_DIV,  32'd0);
    bus_wr(A_CTRL, 32'h1);
    gen_start(12, 2, 806);
    irq_seen = 1'b0;
    for (int i = 0; i < 3*806*12 + 50; i++) begin
      @(posedge clk);
      #1;
      if (user_interrupt) irq_seen = 1'b1;
    end
    gen_stop();
    check("far_line_irq_seen", {31'd0, irq_seen}, 32'h0);
    check_reg("far_line_status", A_CTRL, 32'h3);
    check_reg("far_line_hper", A_HPER, MEAS ? 32'd12  : 32'd0);
    check_reg("far_line_hpul", A_HPUL, MEAS ? 32'd2   : 32'd0);
    check_reg("far_line_vlin", A_VLIN, MEAS ? 32'd806 : 32'd0);
    bus_wr(A_CTRL, 32'h3);
    check_reg("abort_status", A_CTRL, 32'h1);
    check("abort_irq", {31'd0, user_interrupt}, 32'h0);

    // X_START 0, SAMPLE_DIV 0: samples on edge E and the 15 following edges.
    bus_wr(A_LSEL, 32'd0);
    bus_wr(A_XST,  32'd0);
    bus_wr(A_DIV,  32'd0);
    bus_wr(A_CTRL, 32'h1);
    step(1'b1, 1'b0, 6'd0);
    step(1'b1, 1'b1, 6'd0);
    step(1'b0, 1'b1, man_colour(0));
    for (int k = 1; k < 16; k++) begin
      step(1'b0, 1'b1, man_colour(k));
      if (k == 14) check("x0_irq_before_last", {31'd0, user_interrupt}, 32'h0);
      if (k == 15) check("x0_irq_after_last",  {31'd0, user_interrupt}, 32'h1);
    end
    check_reg("x0_status", A_CTRL, 32'h5);
    for (int n = 0; n < 4; n++)
      check_reg($sformatf("x0_buf%0d", n), 6'(32'h20 + 4*n),
                {2'b00, man_colour(4*n+3), 2'b00, man_colour(4*n+2),
                 2'b00, man_colour(4*n+1), 2'b00, man_colour(4*n)});

    // Coincident vsync/hsync fall leaves line_cnt = 1, so the next fall is
    // line 1; then reset lands while the FSM is in SAMPLE.
    bus_wr(A_LSEL, 32'd1);
    bus_wr(A_DIV,  32'd2);
    bus_wr(A_CTRL, 32'h1);
    step(1'b1, 1'b1, 6'd0);
    step(1'b0, 1'b0, 6'h11);
    step(1'b1, 1'b1, 6'd0);
    step(1'b1, 1'b1, 6'd0);
    step(1'b0, 1'b1, 6'h22);
    check_reg("coinc_buf0", A_BUF0, 32'h0000_0022);
    check_reg("coinc_status", A_CTRL, 32'h3);
    step(1'b0, 1'b1, 6'h33);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reg("rsts_status", A_CTRL, 32'h0);
    check_reg("rsts_buf0",   A_BUF0, 32'h0);
    check_reg("rsts_lsel",   A_LSEL, 32'h0);
    check_reg("rsts_div",    A_DIV,  32'h0);
    check_reg("rsts_hper",   A_HPER, 32'h0);
    check_reg("rsts_vlin",   A_VLIN, 32'h0);
    check("rsts_irq",   {31'd0, user_interrupt}, 32'h0);
    check("rsts_uo",    {24'd0, uo_out}, 32'h0);
    check("rsts_ready", {31'd0, data_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
